umq_access_arbiter: RTL

Sequences all accesses to the unexpected-message CAM (UMQ). Arbitrates between network-side inserts and receive-side find requests, which share CAM write port A. Guarantees one outstanding CAM operation at a time, holds the request address stable across the find, tracks occupancy for backpressure, and returns find results over a valid/ready response channel.

---
 rtl/umq_pkg.sv | 28 ++
 rtl/umq_access_arbiter_if.sv | 41 ++++
 rtl/umq_occupancy_ctr.sv | 44 ++++
 rtl/umq_access_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/umq_pkg.sv
// Shared types and constants for the unexpected-message CAM access arbiter.
package umq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIns,
    StFindIssue,
    StFindWait,
    StResp
  } arb_state_t;

  localparam int unsigned UMQ_ADDR_WIDTH = 16;
  localparam int unsigned UMQ_CAPACITY   = (1 << UMQ_ADDR_WIDTH) - 1;
  localparam int unsigned REQ_ADDR_LSB   = 0;
  localparam int unsigned REQ_ADDR_MSB   = 15;

  typedef struct packed {
    logic        found;
    logic        timeout;
    logic [31:0] data;
  } umq_rsp_t;

  // The all-ones address is reserved, so an N-bit CAM holds 2**N-1 entries.
  function automatic int unsigned umq_capacity(input int unsigned addr_width);
    return (1 << addr_width) - 1;
  endfunction

endpackage

// File: rtl/umq_access_arbiter_if.sv
// Insert, find, response and CAM-side signals of the UMQ access arbiter.
interface umq_access_arbiter_if #(
  parameter int unsigned PACKETIZER_WIDTH = 128
);

  logic                        ins_valid;
  logic                        ins_ready;
  logic [PACKETIZER_WIDTH-1:0] ins_message;
  logic                        find_valid;
  logic                        find_ready;
  logic [31:0]                 find_request;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_found;
  logic                        rsp_timeout;
  logic [31:0]                 rsp_data;
  logic                        cam_insert;
  logic [PACKETIZER_WIDTH-1:0] cam_message;
  logic                        cam_find;
  logic [31:0]                 cam_request;
  logic                        cam_found;
  logic                        cam_not_found;
  logic [31:0]                 cam_data;

  // Arbiter view.
  modport slave (
    input  ins_valid, ins_message, find_valid, find_request, rsp_ready,
           cam_found, cam_not_found, cam_data,
    output ins_ready, find_ready, rsp_valid, rsp_found, rsp_timeout, rsp_data,
           cam_insert, cam_message, cam_find, cam_request
  );

  // Requesters, response consumer and CAM view.
  modport master (
    output ins_valid, ins_message, find_valid, find_request, rsp_ready,
           cam_found, cam_not_found, cam_data,
    input  ins_ready, find_ready, rsp_valid, rsp_found, rsp_timeout, rsp_data,
           cam_insert, cam_message, cam_find, cam_request
  );

endinterface

// File: rtl/umq_occupancy_ctr.sv
// Saturating up/down count of CAM entries; increment blocked when full.
module umq_occupancy_ctr
  import umq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  output logic [ADDR_WIDTH-1:0] occupancy,
  output logic                  full
);

  localparam logic [ADDR_WIDTH-1:0] Cap    = ADDR_WIDTH'(umq_capacity(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] OccOne = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] occ_q, occ_d;
  logic                  do_inc, do_dec;

  assign full   = (occ_q == Cap);
  assign do_inc = inc & ~full;
  assign do_dec = dec & (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (do_inc && !do_dec) begin
      occ_d = occ_q + OccOne;
    end else if (do_dec && !do_inc) begin
      occ_d = occ_q - OccOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: rtl/umq_access_arbiter.sv
// Serialises inserts and finds onto the shared UMQ CAM port, one operation at a time.
// Optional event counters are enabled with the UMQ_ARB_STATS_EN macro.
module umq_access_arbiter
  import umq_pkg::*;
#(
  parameter int unsigned PACKETIZER_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned MAX_INS_BURST    = 4,
  parameter int unsigned FIND_TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  umq_access_arbiter_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] occupancy,
  output logic                  full
`ifdef UMQ_ARB_STATS_EN
  , output logic [31:0]         stat_inserts
  , output logic [31:0]         stat_hits
  , output logic [31:0]         stat_misses
  , output logic [31:0]         stat_timeouts
`endif
);

  localparam int unsigned BurstW = $clog2(MAX_INS_BURST + 1);
  localparam int unsigned TmoW   = $clog2(FIND_TIMEOUT + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_INS_BURST);
  localparam logic [BurstW-1:0] BurstOne = BurstW'(1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(FIND_TIMEOUT - 1);
  localparam logic [TmoW-1:0]   TmoOne   = TmoW'(1);

  arb_state_t                  state_q;
  logic [BurstW-1:0]           burst_q;
  logic [TmoW-1:0]             tmo_q;
  umq_rsp_t                    rsp_q;
  logic                        rsp_valid_q;
  logic                        cam_insert_q;
  logic                        cam_find_q;
  logic [PACKETIZER_WIDTH-1:0] cam_message_q;
  logic [31:0]                 cam_request_q;

  logic is_idle, in_wait, grant_ins, grant_find;
  logic wait_hit, wait_miss, wait_tmo;

  assign is_idle = (state_q == StIdle);
  assign in_wait = (state_q == StFindWait);

  // Readies are gated by reset so every output reads 0 while rst is low.
  assign bus.ins_ready  = rst & is_idle & ~full;
  assign bus.find_ready = rst & is_idle;

  assign grant_find = bus.find_valid & bus.find_ready &
                      (~(bus.ins_valid & bus.ins_ready) | (burst_q == BurstMax));
  assign grant_ins  = bus.ins_valid & bus.ins_ready & ~grant_find;

  // A simultaneous hit and miss counts as a hit.
  assign wait_hit  = in_wait & bus.cam_found;
  assign wait_miss = in_wait & ~bus.cam_found & bus.cam_not_found;
  assign wait_tmo  = in_wait & ~bus.cam_found & ~bus.cam_not_found & (tmo_q == TmoLast);

  umq_occupancy_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_occupancy_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_ins),
    .dec      (wait_hit),
    .occupancy(occupancy),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      burst_q       <= '0;
      tmo_q         <= '0;
      rsp_q         <= '0;
      rsp_valid_q   <= 1'b0;
      cam_insert_q  <= 1'b0;
      cam_find_q    <= 1'b0;
      cam_message_q <= '0;
      cam_request_q <= '0;
    end else begin
      cam_insert_q <= 1'b0;
      cam_find_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_find || !bus.find_valid) begin
            burst_q <= '0;
          end else if (grant_ins) begin
            burst_q <= burst_q + BurstOne;
          end
          if (grant_ins) begin
            state_q       <= StIns;
            cam_insert_q  <= 1'b1;
            cam_message_q <= bus.ins_message;
          end else if (grant_find) begin
            state_q       <= StFindIssue;
            cam_find_q    <= 1'b1;
            cam_request_q <= bus.find_request;
          end
        end
        StIns: begin
          state_q <= StIdle;
        end
        StFindIssue: begin
          state_q <= StFindWait;
          tmo_q   <= '0;
        end
        StFindWait: begin
          if (wait_hit) begin
            rsp_q       <= '{found: 1'b1, timeout: 1'b0, data: bus.cam_data};
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (wait_miss) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (wait_tmo) begin
            rsp_q       <= '{found: 1'b0, timeout: 1'b1, data: 32'd0};
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            tmo_q <= tmo_q + TmoOne;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_found   = rsp_q.found;
  assign bus.rsp_timeout = rsp_q.timeout;
  assign bus.rsp_data    = rsp_q.data;
  assign bus.cam_insert  = cam_insert_q;
  assign bus.cam_find    = cam_find_q;
  assign bus.cam_message = cam_message_q;
  assign bus.cam_request = cam_request_q;

`ifdef UMQ_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_inserts  <= '0;
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (grant_ins) stat_inserts  <= stat_inserts + 32'd1;
      if (wait_hit)  stat_hits     <= stat_hits + 32'd1;
      if (wait_miss) stat_misses   <= stat_misses + 32'd1;
      if (wait_tmo)  stat_timeouts <= stat_timeouts + 32'd1;
    end
  end
`endif

endmodule
